// File: rtl/fb_arb_pkg.sv
// Shared types for the framebuffer RAM arbiter: requester identity and read-return tags.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_VID  = 2'd1,
        REQ_CPU  = 2'd2
    } req_owner_t;

    typedef struct packed {
        logic       valid;
        req_owner_t owner;
    } rd_tag_t;

    localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, owner: REQ_NONE};

endpackage

// File: rtl/fb_arb_rdpipe.sv
// Read-tag shift pipe matching the RAM read latency; the tag leaving the pipe
// steers mem_rdata to whichever port issued the read.
module fb_arb_rdpipe
    import fb_arb_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  rd_tag_t           i_tag,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_vid_rvalid,
    output logic [DATA_W-1:0] o_vid_rdata,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata
);

    rd_tag_t w_tail;

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            rd_tag_t r_stage;
            rd_tag_t w_prev;

            if (gi == 0) begin : g_head
                assign w_prev = i_tag;
            end else begin : g_link
                assign w_prev = g_stage[gi-1].r_stage;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stage <= RD_TAG_IDLE;
                end else begin
                    r_stage <= w_prev;
                end
            end
        end
    endgenerate

    assign w_tail = g_stage[RD_LAT-1].r_stage;

    // Data is zeroed outside the valid pulse so idle outputs stay at their reset value.
    assign o_vid_rvalid = w_tail.valid && (w_tail.owner == REQ_VID);
    assign o_cpu_rvalid = w_tail.valid && (w_tail.owner == REQ_CPU);
    assign o_vid_rdata  = o_vid_rvalid ? i_mem_rdata : '0;
    assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : '0;

endmodule

// File: rtl/fb_mem_arbiter.sv
// Single-port framebuffer RAM arbiter: video has priority, CPU starvation bounded by CPU_MAX_WAIT.
// Define FB_ARB_STATS_EN to add grant/forced-grant statistics counters.
module fb_mem_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int RD_LAT       = 2,
    parameter int CPU_MAX_WAIT = 8
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                vid_req,
    input  logic [ADDR_W-1:0]   vid_addr,
    output logic                vid_gnt,
    output logic [DATA_W-1:0]   vid_rdata,
    output logic                vid_rvalid,
    input  logic [ADDR_W-1:0]   avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [DATA_W-1:0]   avs_writedata,
    input  logic [DATA_W/8-1:0] avs_byteenable,
    output logic                avs_waitrequest,
    output logic [DATA_W-1:0]   avs_readdata,
    output logic                avs_readdatavalid,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
`ifdef FB_ARB_STATS_EN
    ,
    output logic [31:0]         stat_vid_grants,
    output logic [31:0]         stat_cpu_grants,
    output logic [15:0]         stat_forced
`endif
);

    localparam int             CW       = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [CW-1:0]  WAIT_MAX = CW'(CPU_MAX_WAIT);

    logic          r_run;
    logic [CW-1:0] r_wait_cnt;
    logic          w_vid_req;
    logic          w_cpu_req;
    logic          w_vid_gnt;
    logic          w_cpu_gnt;
    logic          w_forced;
    rd_tag_t       w_tag;

    // r_run holds grants off until the first clock after reset release, so no
    // request can be accepted while the arbiter state is still being cleared.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign w_vid_req = r_run & vid_req;
    assign w_cpu_req = r_run & (avs_read | avs_write);

    always_comb begin
        w_vid_gnt = 1'b0;
        w_cpu_gnt = 1'b0;
        w_forced  = 1'b0;
        if (w_cpu_req && (r_wait_cnt == WAIT_MAX)) begin
            w_cpu_gnt = 1'b1;
            w_forced  = w_vid_req;
        end else if (w_vid_req) begin
            w_vid_gnt = 1'b1;
        end else if (w_cpu_req) begin
            w_cpu_gnt = 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wait_cnt <= '0;
        end else if (!w_cpu_req || w_cpu_gnt) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != WAIT_MAX) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end

    assign vid_gnt         = w_vid_gnt;
    assign avs_waitrequest = ~r_run | (w_cpu_req & ~w_cpu_gnt);

    // A simultaneous read+write from the CPU is issued as a write.
    assign mem_addr  = w_cpu_gnt ? avs_address : vid_addr;
    assign mem_we    = w_cpu_gnt & avs_write;
    assign mem_be    = w_cpu_gnt ? avs_byteenable : {(DATA_W/8){1'b1}};
    assign mem_wdata = avs_writedata;

    assign w_tag.valid = w_vid_gnt | (w_cpu_gnt & ~avs_write);
    assign w_tag.owner = w_vid_gnt ? REQ_VID : (w_cpu_gnt ? REQ_CPU : REQ_NONE);

    fb_arb_rdpipe #(
        .RD_LAT (RD_LAT),
        .DATA_W (DATA_W)
    ) u_rdpipe (
        .clk          (clk_clk),
        .rst_n        (reset_reset_n),
        .i_tag        (w_tag),
        .i_mem_rdata  (mem_rdata),
        .o_vid_rvalid (vid_rvalid),
        .o_vid_rdata  (vid_rdata),
        .o_cpu_rvalid (avs_readdatavalid),
        .o_cpu_rdata  (avs_readdata)
    );

`ifdef FB_ARB_STATS_EN
    logic [31:0] r_stat_vid;
    logic [31:0] r_stat_cpu;
    logic [15:0] r_stat_forced;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_stat_vid    <= '0;
            r_stat_cpu    <= '0;
            r_stat_forced <= '0;
        end else begin
            if (w_vid_gnt) r_stat_vid    <= r_stat_vid + 32'd1;
            if (w_cpu_gnt) r_stat_cpu    <= r_stat_cpu + 32'd1;
            if (w_forced)  r_stat_forced <= r_stat_forced + 16'd1;
        end
    end

    assign stat_vid_grants = r_stat_vid;
    assign stat_cpu_grants = r_stat_cpu;
    assign stat_forced     = r_stat_forced;
`endif

endmodule
